multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states. Waits on a memory ready handshake with a bounded timeout, traps on illegal opcodes or timeouts, and counts retired instructions. Sits between the instruction register/opcode field and the datapath muxes, register file, ALU control and data memory.

Parameters:
OP_W, 6, opcode field width
ALUOP_W, 2, width of alu_op to ALU control
TIMEOUT, 15, maximum wait cycles for mem_ready before trapping (must be 1 or more)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enables instruction sequencing
opcode  in  OP_W  opcode field of the instruction register; sampled in DECODE only
mem_ready  in  1  memory handshake: current fetch/read/write completes this cycle
clear_trap  in  1  leaves TRAP for IDLE
pc_write  out  1  PC update strobe
ir_write  out  1  instruction register load strobe
mem_read  out  1  memory read request (fetch or lw)
mem_write  out  1  memory write request (sw)
reg_write  out  1  register file write enable
reg_dst  out  1  1 = rd (R type), 0 = rt (I type)
alu_src  out  1  1 = extended immediate, 0 = register
mem_to_reg  out  1  1 = memory data, 0 = ALU result
alu_op  out  ALUOP_W  R=2, add=0, sub=1, none=3 (zero-extended to ALUOP_W)
instr_done  out  1  one-cycle pulse on retire
trap  out  1  high while in TRAP
trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout
retired  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: R=000000, sw=010000, lw=010001, addi=001100, subi=001101. All others are illegal. When OP_W>6, the upper bits must be zero.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset and any rst_n low, including mid-instruction, force IDLE.
- Reset values: all strobes 0, alu_op=3, trap=0, trap_cause=0, retired=0, wait counter=0, latched opcode=0.
- Outputs are decoded from the registered state and the latched opcode only. There is no combinational path from opcode or mem_ready to outputs, except ir_write and pc_write in FETCH, which equal mem_ready.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: mem_read=1. If mem_ready=1, ir_write=1, pc_write=1 and go to DECODE. Otherwise increment the wait counter.
- DECODE: latch opcode. If illegal, go to TRAP with trap_cause=1. Otherwise go to EXEC.
- EXEC: alu_op and alu_src per type (R: 2/0; lw, sw, addi: 0/1; subi: 1/1). lw and sw go to MEM; R, addi and subi go to WB.
- MEM: lw sets mem_read=1; sw sets mem_write=1. alu_op and alu_src are held. On mem_ready, lw goes to WB. On mem_ready, sw retires: instr_done=1 that cycle, then IDLE if run=0, else FETCH.
- WB: reg_write=1 for one cycle. reg_dst=1 only for R. mem_to_reg=1 only for lw. instr_done=1. Next state is FETCH if run=1, else IDLE.
- Wait counter: cleared on entering FETCH or MEM. If it reaches TIMEOUT with mem_ready still 0, go to TRAP with trap_cause=2. mem_ready in the same cycle the counter reaches TIMEOUT wins, and the access completes.
- run deasserted mid-instruction: the current instruction finishes, then the FSM goes to IDLE.
- TRAP: all strobes 0 and trap=1. trap_cause holds until clear_trap=1, which moves to IDLE and clears trap_cause. The trapped instruction is not counted.
- retired increments on each instr_done and wraps from 2^CNT_W-1 to 0.
- Latency per instruction with immediate mem_ready: R, addi, subi and sw take 4 cycles; lw takes 5 cycles.

Test Plan:
- Reset, run=1, mem_ready=1 always, opcode=000000 → FETCH→DECODE→EXEC→WB. WB shows reg_write=1, reg_dst=1, alu_op=2, instr_done=1; retired=1 after 4 cycles.
- lw (010001) with mem_ready low for 3 MEM cycles → mem_read held 4 cycles, then WB with mem_to_reg=1, reg_dst=0. Total 8 cycles, retired increments by 1.
- sw (010000) → MEM with mem_write=1, alu_src=1, alu_op=0. instr_done is asserted in MEM, reg_write stays 0 throughout.
- opcode=111111 → trap=1, trap_cause=1, no reg_write or instr_done. clear_trap=1 → IDLE, trap_cause=0.
- mem_ready held 0 in FETCH → trap_cause=2 after TIMEOUT (15) wait cycles. Repeat with mem_ready rising exactly at count 15 → no trap.
- CNT_W=4, 16 subi instructions → alu_op=1 each; retired wraps 15→0. Assert rst_n low in MEM of a lw → outputs return to reset values immediately.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb with a bounded mem_ready wait, trap on illegal opcode or timeout.
// Latency 4 cycles (5 for lw) with immediate mem_ready; a stalled memory holds the FSM in FETCH/MEM until ready or TIMEOUT.
module multicycle_control #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    input  logic               clear_trap,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] TO_CNT = WC_W'(TIMEOUT);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(6'b001101);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_R    = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_NONE = ALUOP_W'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OP_W-1:0]   op_q;
    logic [WC_W-1:0]   wait_cnt;
    logic [1:0]        cause_nxt;
    logic              op_ok;
    logic              timed_out;
    logic              is_r, is_lw, is_sw, is_subi;

    // Legality is judged on the live opcode (DECODE); everything after uses the latched copy.
    assign op_ok = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_LW) ||
                   (opcode == OP_ADDI) || (opcode == OP_SUBI);

    assign is_r    = (op_q == OP_R);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_subi = (op_q == OP_SUBI);

    // A ready arriving on the terminal count still completes the access.
    assign timed_out = (wait_cnt == TO_CNT) && !mem_ready;

    always_comb begin
        state_nxt  = state;
        cause_nxt  = trap_cause;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_NONE;
        instr_done = 1'b0;
        trap       = 1'b0;

        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            if (is_r)
                alu_op = ALU_R;
            else if (is_subi)
                alu_op = ALU_SUB;
            else
                alu_op = ALU_ADD;
            alu_src = !is_r;
        end

        case (state)
            S_IDLE: begin
                if (run)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'd2;
                end
            end
            S_DECODE: begin
                if (op_ok) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'd1;
                end
            end
            S_EXEC: begin
                state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_nxt = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_nxt  = run ? S_FETCH : S_IDLE;
                    end
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'd2;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                instr_done = 1'b1;
                state_nxt  = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (clear_trap) begin
                    state_nxt = S_IDLE;
                    cause_nxt = 2'd0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
            retired    <= '0;
        end else begin
            state      <= state_nxt;
            trap_cause <= cause_nxt;
            if (state == S_DECODE)
                op_q <= opcode;
            // Any state change restarts the count, so each FETCH/MEM visit begins at zero.
            if (state_nxt != state || !(state == S_FETCH || state == S_MEM))
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (instr_done)
                retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions driven open-loop, expected retire/trap events checked via a scoreboard queue.
module tb_multicycle_control;

    localparam int TO    = 15;
    localparam int NEVER = 99;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       clear_trap = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       reg_dst, alu_src, mem_to_reg, instr_done, trap;
    logic [1:0] alu_op, trap_cause;
    logic [3:0] retired;

    multicycle_control #(.OP_W(6), .ALUOP_W(2), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .clear_trap(clear_trap), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        logic [1:0] e_alu;
        logic       e_src;
        logic       e_dst;
        logic       e_m2r;
        int         e_rw;
        logic [1:0] e_cause;
    } vec_t;

    typedef struct {
        int         evt;
        logic       trapped;
        logic [1:0] cause;
        logic [1:0] alu;
        logic       src, dst, m2r;
        int         rd, wr, rw, ir;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    vec_t tbl [13];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: counts strobes per instruction and pops on each retire or trap entry.
    bit         mon_en = 1'b0;
    int         rd_cnt = 0, wr_cnt = 0, rw_cnt = 0, ir_cnt = 0, pc_cnt = 0;
    logic       trap_q = 1'b0;
    logic [3:0] exp_ret = 4'd0;

    always @(negedge clk) begin
        if (!mon_en) begin
            rd_cnt = 0; wr_cnt = 0; rw_cnt = 0; ir_cnt = 0; pc_cnt = 0;
            trap_q = 1'b0; exp_ret = 4'd0;
        end else begin
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (reg_write) rw_cnt++;
            if (ir_write)  ir_cnt++;
            if (pc_write)  pc_cnt++;
            if (instr_done || (trap && !trap_q)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("event_cycle", cyc, me.evt);
                    chk("trap", trap, me.trapped);
                    chk("instr_done", instr_done, !me.trapped);
                    chk("trap_cause", trap_cause, me.cause);
                    chk("alu_op", alu_op, me.alu);
                    chk("alu_src", alu_src, me.src);
                    chk("reg_dst", reg_dst, me.dst);
                    chk("mem_to_reg", mem_to_reg, me.m2r);
                    chk("mem_read_cycles", rd_cnt, me.rd);
                    chk("mem_write_cycles", wr_cnt, me.wr);
                    chk("reg_write_cycles", rw_cnt, me.rw);
                    chk("ir_write_cycles", ir_cnt, me.ir);
                    chk("pc_write_cycles", pc_cnt, me.ir);
                    chk("retired", retired, exp_ret);
                    if (!me.trapped) exp_ret++;
                end
                rd_cnt = 0; wr_cnt = 0; rw_cnt = 0; ir_cnt = 0; pc_cnt = 0;
            end
            trap_q = trap;
        end
    end

    // Drives one instruction open-loop from the current cycle. cont: FSM already in FETCH this cycle.
    // nxt: keep run high so the next instruction follows directly.
    task automatic issue(input vec_t v, input bit cont, input bit nxt);
        exp_t e;
        int   cur, f0, m, mc, last;
        bit   lw, sw;
        lw  = (v.op == 6'b010001);
        sw  = (v.op == 6'b010000);
        cur = cyc;
        f0  = cont ? cur : cur + 1;
        m   = f0 + v.fw + 3;
        e.trapped = (v.e_cause != 2'd0);
        e.cause = v.e_cause; e.alu = v.e_alu; e.src = v.e_src;
        e.dst = v.e_dst; e.m2r = v.e_m2r; e.rw = v.e_rw;
        e.ir = (v.fw > TO) ? 0 : 1;
        e.wr = 0;
        if (v.fw > TO) begin
            e.evt = f0 + TO + 1;
            e.rd  = TO + 1;
        end else if (v.e_cause == 2'd1 || !(lw || sw)) begin
            e.evt = (v.e_cause == 2'd1) ? f0 + v.fw + 2 : f0 + v.fw + 3;
            e.rd  = v.fw + 1;
        end else begin
            mc    = (v.mw > TO) ? TO + 1 : v.mw + 1;
            e.evt = (v.mw > TO) ? m + TO + 1 : (lw ? m + v.mw + 1 : m + v.mw);
            e.rd  = v.fw + 1 + (lw ? mc : 0);
            e.wr  = sw ? mc : 0;
        end
        sb.push_back(e);
        opcode = v.op;
        last = e.trapped ? e.evt + 2 : e.evt;
        for (int c = cur; c <= last; c++) begin
            run        = (c == cur && !cont) ? 1'b1 : (nxt && !e.trapped);
            mem_ready  = (c == f0 + v.fw) || ((lw || sw) && c == m + v.mw);
            clear_trap = e.trapped && (c == last);
            if (e.trapped && c == e.evt + 1) begin
                @(negedge clk);
                chk("trap_held", trap, 1);
                chk("trap_cause_held", trap_cause, v.e_cause);
            end
            @(posedge clk); #1;
        end
        clear_trap = 1'b0;
        if (e.trapped) begin
            @(negedge clk);
            chk("trap_cleared", trap, 0);
            chk("trap_cause_cleared", trap_cause, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_write"}, pc_write, 0);
        chk({tag, "_ir_write"}, ir_write, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_reg_write"}, reg_write, 0);
        chk({tag, "_reg_dst"}, reg_dst, 0);
        chk({tag, "_alu_src"}, alu_src, 0);
        chk({tag, "_mem_to_reg"}, mem_to_reg, 0);
        chk({tag, "_alu_op"}, alu_op, 3);
        chk({tag, "_instr_done"}, instr_done, 0);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_trap_cause"}, trap_cause, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    initial begin
        //          op         fw     mw     alu   src   dst   m2r   rw cause
        tbl[0]  = '{6'b000000, 0,     0,     2'd2, 1'b0, 1'b1, 1'b0, 1, 2'd0};
        tbl[1]  = '{6'b010001, 0,     3,     2'd0, 1'b1, 1'b0, 1'b1, 1, 2'd0};
        tbl[2]  = '{6'b010000, 0,     0,     2'd0, 1'b1, 1'b0, 1'b0, 0, 2'd0};
        tbl[3]  = '{6'b001100, 2,     0,     2'd0, 1'b1, 1'b0, 1'b0, 1, 2'd0};
        tbl[4]  = '{6'b001101, 0,     0,     2'd1, 1'b1, 1'b0, 1'b0, 1, 2'd0};
        tbl[5]  = '{6'b111111, 0,     0,     2'd3, 1'b0, 1'b0, 1'b0, 0, 2'd1};
        tbl[6]  = '{6'b110001, 1,     0,     2'd3, 1'b0, 1'b0, 1'b0, 0, 2'd1};
        tbl[7]  = '{6'b000000, NEVER, 0,     2'd3, 1'b0, 1'b0, 1'b0, 0, 2'd2};
        tbl[8]  = '{6'b000000, TO,    0,     2'd2, 1'b0, 1'b1, 1'b0, 1, 2'd0};
        tbl[9]  = '{6'b010000, 0,     NEVER, 2'd3, 1'b0, 1'b0, 1'b0, 0, 2'd2};
        tbl[10] = '{6'b010001, 1,     TO,    2'd0, 1'b1, 1'b0, 1'b1, 1, 2'd0};
        tbl[11] = '{6'b010000, 0,     2,     2'd0, 1'b1, 1'b0, 1'b0, 0, 2'd0};
        tbl[12] = '{6'b001101, 3,     0,     2'd1, 1'b1, 1'b0, 1'b0, 1, 2'd0};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Each instruction alone, run dropped after the start cycle.
        for (int i = 0; i < 13; i++)
            issue(tbl[i], 1'b0, 1'b0);

        // Back-to-back with run held high, including sw retiring straight into FETCH.
        issue(tbl[0], 1'b0, 1'b1);
        issue(tbl[3], 1'b1, 1'b1);
        issue(tbl[2], 1'b1, 1'b1);
        issue(tbl[1], 1'b1, 1'b0);

        // Sixteen subi in a row carry the 4-bit retired count through its wrap.
        for (int i = 0; i < 16; i++)
            issue(tbl[4], i > 0, i < 15);

        // Reset asserted while a lw waits in MEM.
        mon_en = 1'b0;
        opcode = 6'b010001;
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        run = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_lw_mem_read", mem_read, 1);
        chk("mid_lw_alu_src", alu_src, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        issue(tbl[0], 1'b0, 1'b0);
        issue(tbl[1], 1'b0, 1'b0);

        repeat (2) begin @(posedge clk); #1; end
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_retired", retired, exp_ret);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
